xor_stream_cipher: RTL and testbench

// - Parametrised streaming XOR cipher; successor of the 8-bit bit-serial XOR block.
// - Encrypts/decrypts a message of LEN words over valid/ready in/out streams.
// - Keystream comes from a rotating static key (mode 0) or a Galois LFSR (mode 1).
// - Sits between the host data source and the link/storage sink.
// - Encrypt and decrypt are the same operation.

---
 rtl/xor_cipher_pkg.sv | 20 ++
 rtl/xor_keystream_gen.sv | 58 +++++
 rtl/xor_stream_cipher.sv | 109 ++++++++++
 tb/tb_xor_stream_cipher.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_pkg.sv
`default_nettype none
// ==========================================================================
// xor_cipher_pkg : shared types and constants for the XOR stream cipher
// Revision 1.0
// ==========================================================================
package xor_cipher_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic MODE_ROT  = 1'b0;
   localparam logic MODE_LFSR = 1'b1;

   localparam logic [31:0] DEFAULT_LFSR_POLY = 32'h80200003;

endpackage
`default_nettype wire

// File: rtl/xor_keystream_gen.sv
`default_nettype none
// ==========================================================================
// xor_keystream_gen : rotating-key or Galois-LFSR keystream register
// Revision 1.0
// ==========================================================================
module xor_keystream_gen
   import xor_cipher_pkg::*;
#(
   parameter int              KEY_W     = 32,
   parameter int              DATA_W    = 8,
   parameter logic [KEY_W-1:0] LFSR_POLY = KEY_W'(DEFAULT_LFSR_POLY)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              load_i,
   input  logic [KEY_W-1:0]  seed_i,
   input  logic              mode_i,
   input  logic              advance_i,
   output logic [DATA_W-1:0] ks_o
);

   logic [KEY_W-1:0] key_q, key_d;
   logic             mode_q, mode_d;

   always_comb begin
      key_d  = key_q;
      mode_d = mode_q;
      if (load_i) begin
         mode_d = mode_i;
         // An all-zero LFSR would never leave zero, so force a non-zero seed
         if (mode_i == MODE_LFSR && seed_i == '0) begin
            key_d = KEY_W'(1);
         end else begin
            key_d = seed_i;
         end
      end else if (advance_i) begin
         if (mode_q == MODE_ROT) begin
            key_d = (key_q >> DATA_W) | (key_q << (KEY_W - DATA_W));
         end else begin
            key_d = (key_q >> 1) ^ (key_q[0] ? LFSR_POLY : '0);
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         key_q  <= '0;
         mode_q <= MODE_ROT;
      end else begin
         key_q  <= key_d;
         mode_q <= mode_d;
      end
   end

   assign ks_o = key_q[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/xor_stream_cipher.sv
`default_nettype none
// ==========================================================================
// xor_stream_cipher : streaming XOR cipher with valid/ready in/out ports
// Revision 1.0
// ==========================================================================
module xor_stream_cipher
   import xor_cipher_pkg::*;
#(
   parameter int               DATA_W    = 8,
   parameter int               KEY_W     = 32,
   parameter int               LEN_W     = 16,
   parameter logic [KEY_W-1:0] LFSR_POLY = KEY_W'(DEFAULT_LFSR_POLY)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              mode_i,
   input  logic [KEY_W-1:0]  key_i,
   input  logic [LEN_W-1:0]  msg_len_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   input  logic              out_ready_i,
   output logic              done_o
);

   state_e            state_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  count_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              done_q;

   logic              load_w;
   logic              in_hs_w;
   logic              out_hs_w;
   logic [DATA_W-1:0] ks_w;

   assign load_w     = (state_q == ST_IDLE) && start_i;
   assign in_ready_o = (state_q == ST_RUN) && (!out_valid_q || out_ready_i) && (count_q < len_q);
   assign in_hs_w    = in_valid_i && in_ready_o;
   assign out_hs_w   = (state_q == ST_RUN) && out_valid_q && out_ready_i;

   xor_keystream_gen #(
      .KEY_W     (KEY_W),
      .DATA_W    (DATA_W),
      .LFSR_POLY (LFSR_POLY)
   ) u_ks (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .load_i    (load_w),
      .seed_i    (key_i),
      .mode_i    (mode_i),
      .advance_i (in_hs_w),
      .ks_o      (ks_w)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  len_q       <= msg_len_i;
                  count_q     <= '0;
                  out_valid_q <= 1'b0;
                  state_q     <= ST_RUN;
               end
            end
            ST_RUN: begin
               // A simultaneous input handshake reloads the register so out_valid stays high
               if (in_hs_w) begin
                  out_data_q  <= in_data_i ^ ks_w;
                  out_valid_q <= 1'b1;
                  count_q     <= count_q + 1'b1;
               end else if (out_hs_w) begin
                  out_valid_q <= 1'b0;
               end
               if (count_q == len_q && !out_valid_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!start_i) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_stream_cipher.sv
`default_nettype none
// Scoreboard bench for xor_stream_cipher: drivers push expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_xor_stream_cipher;

   localparam int DATA_W = 8;
   localparam int KEY_W  = 32;
   localparam int LEN_W  = 16;
   localparam logic [31:0] POLY = 32'h80200003;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              mode = 1'b0;
   logic [KEY_W-1:0]  key = '0;
   logic [LEN_W-1:0]  msg_len = '0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready = 1'b1;
   logic              done;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] mon_exp;

   logic [7:0]  pt [16];
   logic [7:0]  ct [16];
   logic [31:0] lfsr;

   always #5 clk = ~clk;

   xor_stream_cipher #(
      .DATA_W (DATA_W),
      .KEY_W  (KEY_W),
      .LEN_W  (LEN_W)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start),
      .mode_i      (mode),
      .key_i       (key),
      .msg_len_i   (msg_len),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_ready_o  (in_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_ready_i (out_ready),
      .done_o      (done)
   );

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got %02h, required no output", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (out_data !== mon_exp) begin
               errors++;
               $display("FAIL out_data: got %02h, required %02h", out_data, mon_exp);
            end
         end
      end
   end

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? POLY : 32'h0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic start_msg(input logic m, input logic [31:0] k, input int len, input bit hold);
      @(posedge clk); #1;
      start = 1'b1; mode = m; key = k; msg_len = LEN_W'(len);
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] e);
      int n;
      bit ok;
      n = 0; ok = 1'b0;
      in_valid = 1'b1; in_data = d;
      while (n < 100) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
         n++;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL in_ready_timeout: got 0, required 1 within 100 cycles");
         in_valid = 1'b0;
      end else begin
         exp_q.push_back(e);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (n < 200 && !done) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 32'(done), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;

      // mode 0, back-to-back
      start_msg(1'b0, 32'h04030201, 4, 1'b0);
      send(8'h10, 8'h11);
      send(8'h20, 8'h22);
      send(8'h30, 8'h33);
      send(8'h40, 8'h44);
      @(posedge clk); #1;
      check("done_early", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("done_after_last", 32'(done), 32'd1);
      @(posedge clk); #1;
      check("done_cleared_idle", 32'(done), 32'd0);

      // sink stall after the first word
      start_msg(1'b0, 32'h04030201, 4, 1'b0);
      send(8'h10, 8'h11);
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_data", 32'(out_data), 32'h11);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(8'h20, 8'h22);
      send(8'h30, 8'h33);
      send(8'h40, 8'h44);
      wait_done();

      // zero-length message
      start_msg(1'b0, 32'h12345678, 0, 1'b1);
      check("len0_done_1cyc", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("len0_done_2cyc", 32'(done), 32'd1);
      check("len0_no_valid", 32'(out_valid), 32'd0);
      start = 1'b0;
      @(posedge clk); #1;
      check("len0_done_drop", 32'(done), 32'd0);

      // LFSR with zero seed
      start_msg(1'b1, 32'h0, 2, 1'b0);
      lfsr = 32'h1;
      send(8'h00, 8'h00 ^ lfsr[7:0]);
      lfsr = lfsr_next(lfsr);
      send(8'h00, 8'h00 ^ lfsr[7:0]);
      check("lfsr_second_ks", lfsr, 32'h80200003);
      wait_done();

      // LFSR round trip
      for (int i = 0; i < 16; i++) pt[i] = 8'((i * 37 + 5) ^ (i << 4));
      start_msg(1'b1, 32'hDEADBEEF, 16, 1'b0);
      lfsr = 32'hDEADBEEF;
      for (int i = 0; i < 16; i++) begin
         ct[i] = pt[i] ^ lfsr[7:0];
         lfsr  = lfsr_next(lfsr);
         send(pt[i], ct[i]);
      end
      wait_done();
      start_msg(1'b1, 32'hDEADBEEF, 16, 1'b0);
      for (int i = 0; i < 16; i++) send(ct[i], pt[i]);
      wait_done();

      // reset mid-message
      start_msg(1'b0, 32'hA5A5A5A5, 4, 1'b0);
      send(8'h01, 8'hA4);
      send(8'h02, 8'hA7);
      reset = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      start_msg(1'b0, 32'h0F0E0D0C, 4, 1'b0);
      send(8'h01, 8'h0D);
      send(8'h02, 8'h0F);
      send(8'h03, 8'h0D);
      send(8'h04, 8'h0B);
      wait_done();

      repeat (3) @(posedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
